// File: rtl/io_periph_mmio.sv
// io_periph_mmio: memory-mapped I/O block for the single-cycle core.
// Holds the red/green LED registers, the seven-segment digit bytes, a
// prescaled free-running timer and the synchronised/debounced switch bank.
// Reads are combinational from registered state; writes commit on the clock
// edge with per-byte enables.
module io_periph_mmio #(
  parameter int NUM_HEX      = 8,
  parameter int LEDR_W       = 17,
  parameter int LEDG_W       = 8,
  parameter int SW_W         = 18,
  parameter int DEBOUNCE_CYC = 16,
  parameter int PRESC        = 50
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_sel,
  input  logic                 i_wren,
  input  logic [11:0]          i_addr,
  input  logic [3:0]           i_be,
  input  logic [31:0]          i_wdata,
  output logic [31:0]          o_rdata,
  input  logic [SW_W-1:0]      i_io_sw,
  output logic [LEDR_W-1:0]    o_io_ledr,
  output logic [LEDG_W-1:0]    o_io_ledg,
  output logic [7*NUM_HEX-1:0] o_io_hex
);

  // Word addresses (byte offset >> 2) inside the I/O window.
  localparam logic [9:0] W_LEDR = 10'h000;
  localparam logic [9:0] W_LEDG = 10'h004;
  localparam logic [9:0] W_HEXL = 10'h008;
  localparam logic [9:0] W_HEXH = 10'h009;
  localparam logic [9:0] W_TCNT = 10'h00C;
  localparam logic [9:0] W_TCTL = 10'h00D;
  localparam logic [9:0] W_SW   = 10'h200;

  // Prescaler counts 0..PRESC-1; a one-bit counter is kept for PRESC == 1.
  localparam int              PW        = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [PW-1:0]   PRESC_MAX = PW'(PRESC - 1);

  // Replace the bytes of old_w selected by be with the bytes of new_w.
  function automatic logic [31:0] merge_be(input logic [31:0] old_w,
                                           input logic [31:0] new_w,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) begin
        res[8*b +: 8] = new_w[8*b +: 8];
      end else begin
        res[8*b +: 8] = old_w[8*b +: 8];
      end
    end
    return res;
  endfunction

  // Active-low segment pattern (bit order g..a) for one digit.
  function automatic logic [6:0] seg_enc(input logic blank, input logic [3:0] val);
    logic [6:0] seg;
    if (blank) begin
      seg = 7'b1111111;
    end else begin
      case (val)
        4'h0:    seg = 7'b1000000;
        4'h1:    seg = 7'b1111001;
        4'h2:    seg = 7'b0100100;
        4'h3:    seg = 7'b0110000;
        4'h4:    seg = 7'b0011001;
        4'h5:    seg = 7'b0010010;
        4'h6:    seg = 7'b0000010;
        4'h7:    seg = 7'b1111000;
        4'h8:    seg = 7'b0000000;
        4'h9:    seg = 7'b0010000;
        4'hA:    seg = 7'b0001000;
        4'hB:    seg = 7'b0000011;
        4'hC:    seg = 7'b1000110;
        4'hD:    seg = 7'b0100001;
        4'hE:    seg = 7'b0000110;
        4'hF:    seg = 7'b0001110;
        default: seg = 7'b1111111;
      endcase
    end
    return seg;
  endfunction

  logic                   wr_s;
  logic [9:0]             word_s;

  logic [LEDR_W-1:0]      ledr_q, ledr_d;
  logic [LEDG_W-1:0]      ledg_q, ledg_d;
  logic [8*NUM_HEX-1:0]   dig_q, dig_d;
  logic [31:0]            ledr_m_s, ledg_m_s;
  logic [63:0]            dig_all_s, dig_m_s;

  logic [31:0]            tcnt_q, tcnt_d;
  logic [PW-1:0]          presc_q, presc_d;
  logic                   ten_q, ten_d;

  logic [SW_W-1:0]        sw_s1_q, sw_s2_q;
  logic [SW_W-1:0]        sw_db_s;

  logic [31:0]            rdata_s;
  logic                   unused_s;

  assign wr_s   = i_sel & i_wren;
  assign word_s = i_addr[11:2];

  // Next state of the LED and digit registers from byte-enabled writes.
  always_comb begin
    ledr_m_s  = merge_be(32'(ledr_q), i_wdata, i_be);
    ledg_m_s  = merge_be(32'(ledg_q), i_wdata, i_be);
    dig_all_s = 64'(dig_q);
    dig_m_s   = dig_all_s;
    ledr_d    = ledr_q;
    ledg_d    = ledg_q;
    if (wr_s) begin
      case (word_s)
        W_LEDR:  ledr_d = ledr_m_s[LEDR_W-1:0];
        W_LEDG:  ledg_d = ledg_m_s[LEDG_W-1:0];
        W_HEXL:  dig_m_s[31:0]  = merge_be(dig_all_s[31:0], i_wdata, i_be);
        W_HEXH:  dig_m_s[63:32] = merge_be(dig_all_s[63:32], i_wdata, i_be);
        default: dig_m_s = dig_all_s;
      endcase
    end else begin
      dig_m_s = dig_all_s;
    end
    // Digits at or beyond NUM_HEX fall off here and are never stored.
    dig_d = dig_m_s[8*NUM_HEX-1:0];
  end

  // Timer next state: prescaled increment, then ctrl write (clear wins).
  always_comb begin
    tcnt_d  = tcnt_q;
    presc_d = presc_q;
    ten_d   = ten_q;
    if (ten_q) begin
      if (presc_q == PRESC_MAX) begin
        presc_d = {PW{1'b0}};
        tcnt_d  = tcnt_q + 32'd1;
      end else begin
        presc_d = presc_q + PW'(1'b1);
      end
    end else begin
      presc_d = presc_q;
    end
    if (wr_s && (word_s == W_TCTL) && i_be[0]) begin
      ten_d = i_wdata[0];
      if (i_wdata[1]) begin
        tcnt_d  = 32'd0;
        presc_d = {PW{1'b0}};
      end else begin
        ten_d = i_wdata[0];
      end
    end else begin
      ten_d = ten_q;
    end
  end

  // Register bank: LEDs, digits and timer state.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      ledr_q  <= {LEDR_W{1'b0}};
      ledg_q  <= {LEDG_W{1'b0}};
      dig_q   <= {(8*NUM_HEX){1'b0}};
      tcnt_q  <= 32'd0;
      presc_q <= {PW{1'b0}};
      ten_q   <= 1'b0;
    end else begin
      ledr_q  <= ledr_d;
      ledg_q  <= ledg_d;
      dig_q   <= dig_d;
      tcnt_q  <= tcnt_d;
      presc_q <= presc_d;
      ten_q   <= ten_d;
    end
  end

  // Two-flop synchroniser for the raw switch inputs.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sw_s1_q <= {SW_W{1'b0}};
      sw_s2_q <= {SW_W{1'b0}};
    end else begin
      sw_s1_q <= i_io_sw;
      sw_s2_q <= sw_s1_q;
    end
  end

  generate
    if (DEBOUNCE_CYC == 0) begin : g_nodb
      assign sw_db_s = sw_s2_q;
    end else begin : g_db
      localparam int            CW     = $clog2(DEBOUNCE_CYC + 1);
      localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_CYC);

      logic [CW-1:0]   cnt_q [SW_W];
      logic [CW-1:0]   cnt_d [SW_W];
      logic [SW_W-1:0] db_q, db_d;

      // Per-bit stability counter; the debounced bit follows once it saturates.
      always_comb begin
        for (int i = 0; i < SW_W; i++) begin
          if (sw_s1_q[i] != sw_s2_q[i]) begin
            cnt_d[i] = {CW{1'b0}};
          end else if (cnt_q[i] != DB_MAX) begin
            cnt_d[i] = cnt_q[i] + CW'(1'b1);
          end else begin
            cnt_d[i] = cnt_q[i];
          end
          if (cnt_d[i] == DB_MAX) begin
            db_d[i] = sw_s2_q[i];
          end else begin
            db_d[i] = db_q[i];
          end
        end
      end

      // Debounce counters and debounced switch state.
      always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
          for (int i = 0; i < SW_W; i++) begin
            cnt_q[i] <= {CW{1'b0}};
          end
          db_q <= {SW_W{1'b0}};
        end else begin
          for (int i = 0; i < SW_W; i++) begin
            cnt_q[i] <= cnt_d[i];
          end
          db_q <= db_d;
        end
      end

      assign sw_db_s = db_q;
    end
  endgenerate

  // Read mux: combinational view of the registered state.
  always_comb begin
    rdata_s = 32'h0000_0000;
    case (word_s)
      W_LEDR:  rdata_s = 32'(ledr_q);
      W_LEDG:  rdata_s = 32'(ledg_q);
      W_HEXL:  rdata_s = dig_all_s[31:0];
      W_HEXH:  rdata_s = dig_all_s[63:32];
      W_TCNT:  rdata_s = tcnt_q;
      W_TCTL:  rdata_s = {31'h0000_0000, ten_q};
      W_SW:    rdata_s = 32'(sw_db_s);
      default: rdata_s = 32'h0000_0000;
    endcase
  end

  assign o_rdata   = rdata_s;
  assign o_io_ledr = ledr_q;
  assign o_io_ledg = ledg_q;

  generate
    for (genvar k = 0; k < NUM_HEX; k++) begin : g_seg
      assign o_io_hex[7*k +: 7] = seg_enc(dig_q[8*k+7], dig_q[8*k +: 4]);
    end
  endgenerate

  // Byte-offset bits and the clipped upper parts of merged words are not needed.
  assign unused_s = ^{i_addr[1:0], ledr_m_s, ledg_m_s, dig_m_s};

endmodule

// File: tb/tb_io_periph_mmio.sv
// Scoreboard bench for io_periph_mmio: stimulus pushes expected values, a
// monitor pops and compares them; random traffic is checked against a
// behavioural model of the register map.
`timescale 1ns/1ps
module tb_io_periph_mmio;
  localparam int NH  = 6;
  localparam int LRW = 17;
  localparam int LGW = 8;
  localparam int SWW = 18;
  localparam int DB  = 16;
  localparam int PS  = 4;
  localparam logic [31:0] LRMASK = 32'((64'd1 << LRW) - 64'd1);
  localparam logic [31:0] LGMASK = 32'((64'd1 << LGW) - 64'd1);

  logic              clk = 1'b0;
  logic              i_rst, i_sel, i_wren;
  logic [11:0]       i_addr;
  logic [3:0]        i_be;
  logic [31:0]       i_wdata, o_rdata;
  logic [SWW-1:0]    i_io_sw;
  logic [LRW-1:0]    o_io_ledr;
  logic [LGW-1:0]    o_io_ledg;
  logic [7*NH-1:0]   o_io_hex;

  always #5 clk = ~clk;

  io_periph_mmio #(.NUM_HEX(NH), .LEDR_W(LRW), .LEDG_W(LGW), .SW_W(SWW),
                   .DEBOUNCE_CYC(DB), .PRESC(PS)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_sel(i_sel), .i_wren(i_wren), .i_addr(i_addr),
    .i_be(i_be), .i_wdata(i_wdata), .o_rdata(o_rdata), .i_io_sw(i_io_sw),
    .o_io_ledr(o_io_ledr), .o_io_ledg(o_io_ledg), .o_io_hex(o_io_hex));

  // ---------------- behavioural model ----------------
  logic [31:0]    ledr_m, ledg_m;
  logic [7:0]     dig_m [NH];
  bit             en_m;
  longint         ticks;          // enabled clocks since the last clear
  logic [SWW-1:0] db_m;
  logic [SWW-1:0] hist [$];       // last DB+1 raw switch samples

  function automatic logic [31:0] merge32(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'h0: return 7'b1000000; 4'h1: return 7'b1111001; 4'h2: return 7'b0100100;
      4'h3: return 7'b0110000; 4'h4: return 7'b0011001; 4'h5: return 7'b0010010;
      4'h6: return 7'b0000010; 4'h7: return 7'b1111000; 4'h8: return 7'b0000000;
      4'h9: return 7'b0010000; 4'hA: return 7'b0001000; 4'hB: return 7'b0000011;
      4'hC: return 7'b1000110; 4'hD: return 7'b0100001; 4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  task automatic model_reset();
    ledr_m = 32'h0; ledg_m = 32'h0; en_m = 1'b0; ticks = 0; db_m = '0;
    for (int k = 0; k < NH; k++) dig_m[k] = 8'h00;
    hist.delete();
    for (int j = 0; j <= DB; j++) hist.push_back('0);
  endtask

  function automatic logic [31:0] exp_read(input logic [11:0] a);
    logic [31:0] r;
    r = 32'h0;
    case (a[11:2])
      10'h000: r = ledr_m;
      10'h004: r = ledg_m;
      10'h008: for (int k = 0; k < 4; k++) if (k < NH) r[8*k +: 8] = dig_m[k];
      10'h009: for (int k = 0; k < 4; k++) if (k + 4 < NH) r[8*k +: 8] = dig_m[k + 4];
      10'h00C: r = 32'(ticks / PS);
      10'h00D: r = {31'h0, en_m};
      10'h200: r = 32'(db_m);
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  function automatic logic [63:0] exp_hex();
    logic [63:0] h;
    h = 64'h0;
    for (int k = 0; k < NH; k++)
      h[7*k +: 7] = dig_m[k][7] ? 7'b1111111 : seg_of(dig_m[k][3:0]);
    return h;
  endfunction

  // Model update on every clock edge and on asynchronous reset.
  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge i_rst);
      if (!i_rst) model_reset();
      else begin
        // a switch bit follows once its last DB+1 samples agree
        for (int b = 0; b < SWW; b++) begin
          bit same;
          same = 1'b1;
          foreach (hist[j]) if (hist[j][b] != hist[0][b]) same = 1'b0;
          if (same) db_m[b] = hist[DB][b];
        end
        hist.push_back(i_io_sw);
        void'(hist.pop_front());
        if (en_m) ticks++;
        if (i_sel && i_wren) begin
          case (i_addr[11:2])
            10'h000: ledr_m = merge32(ledr_m, i_wdata, i_be) & LRMASK;
            10'h004: ledg_m = merge32(ledg_m, i_wdata, i_be) & LGMASK;
            10'h008, 10'h009: begin
              for (int k = 0; k < 4; k++) begin
                int d;
                d = k + (i_addr[2] ? 4 : 0);
                if (i_be[k] && d < NH) dig_m[d] = i_wdata[8*k +: 8];
              end
            end
            10'h00D: if (i_be[0]) begin
              en_m = i_wdata[0];
              if (i_wdata[1]) ticks = 0;
            end
            default: ;
          endcase
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct { int kind; logic [63:0] exp; string name; } item_t;
  item_t exp_q [$];
  event  chk_now;
  int    n_cmp = 0;
  int    n_err = 0;

  task automatic push(input int kind, input logic [63:0] e, input string name);
    item_t it;
    it.kind = kind; it.exp = e; it.name = name;
    exp_q.push_back(it);
  endtask

  // Monitor: compares every queued expectation against the live outputs.
  initial begin
    forever begin
      @(negedge clk or chk_now);
      while (exp_q.size() > 0) begin
        item_t it;
        logic [63:0] act;
        it = exp_q.pop_front();
        case (it.kind)
          0:       act = 64'(o_rdata);
          1:       act = 64'(o_io_ledr);
          2:       act = 64'(o_io_ledg);
          default: act = 64'(o_io_hex);
        endcase
        n_cmp++;
        if (act !== it.exp) begin
          n_err++;
          $display("FAIL %s: actual=%h required=%h", it.name, act, it.exp);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(); @(posedge clk); #1; endtask
  task automatic idle(input int n); repeat (n) @(posedge clk); #1; endtask

  task automatic wr(input logic [11:0] a, input logic [3:0] be, input logic [31:0] d);
    i_sel = 1'b1; i_wren = 1'b1; i_addr = a; i_be = be; i_wdata = d;
    step();
    i_sel = 1'b0; i_wren = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a, input string name);
    i_sel = 1'b1; i_wren = 1'b0; i_addr = a;
    push(0, 64'(exp_read(a)), name);
    step();
    i_sel = 1'b0;
  endtask

  task automatic rd_const(input logic [11:0] a, input logic [31:0] e, input string name);
    i_sel = 1'b1; i_wren = 1'b0; i_addr = a;
    push(0, 64'(e), name);
    step();
    i_sel = 1'b0;
  endtask

  task automatic chk_outs();
    push(1, 64'(ledr_m), "ledr_out");
    push(2, 64'(ledg_m), "ledg_out");
    push(3, exp_hex(), "hex_out");
  endtask

  logic [11:0] addr_tab [11] = '{12'h000, 12'h010, 12'h020, 12'h024, 12'h030, 12'h034,
                                 12'h800, 12'h004, 12'h040, 12'h7FC, 12'hFFC};

  initial begin
    logic [63:0] hz, h;
    hz = 64'h0;
    for (int k = 0; k < NH; k++) hz[7*k +: 7] = 7'b1000000;
    i_rst = 1'b0; i_sel = 1'b0; i_wren = 1'b0; i_addr = 12'h0; i_be = 4'h0;
    i_wdata = 32'h0; i_io_sw = '0;
    idle(3);
    i_rst = 1'b1;
    step();

    // reset state
    push(1, 64'h0, "reset_ledr"); push(2, 64'h0, "reset_ledg"); push(3, hz, "reset_hex");
    rd_const(12'h030, 32'h0, "reset_tcnt");

    // byte-enabled digit write
    wr(12'h020, 4'b0101, 32'h8A030F05);
    h = hz; h[6:0] = 7'b0010010; h[20:14] = 7'b0110000;
    push(3, h, "hex_be_write");
    rd_const(12'h020, 32'h0003_0005, "hex_be_read");

    // blank and width clipping
    wr(12'h020, 4'hF, 32'h0000_0080);
    h = hz; h[6:0] = 7'b1111111;
    push(3, h, "hex_blank");
    wr(12'h000, 4'hF, 32'hFFFF_FFFF);
    rd_const(12'h000, 32'h0001_FFFF, "ledr_clip");
    wr(12'h024, 4'hF, 32'hFFFF_FFFF);
    rd_const(12'h024, 32'h0000_FFFF, "hex_digit_clip");
    wr(12'h040, 4'hF, 32'h1234_5678);
    rd_const(12'h040, 32'h0, "unmapped_read");
    i_sel = 1'b0; i_wren = 1'b1; i_addr = 12'h010; i_be = 4'hF; i_wdata = 32'hFF;
    step(); i_wren = 1'b0;
    rd_const(12'h010, 32'h0, "wren_no_sel");

    // debounce: 5-cycle glitch is rejected, a held level appears after 18 cycles
    i_io_sw[0] = 1'b1;
    for (int i = 0; i < 5; i++) rd_const(12'h800, 32'h0, "sw_glitch");
    i_io_sw[0] = 1'b0;
    for (int i = 0; i < 20; i++) rd_const(12'h803, 32'h0, "sw_glitch_after");
    i_io_sw[0] = 1'b1;
    for (int i = 0; i < 22; i++) rd_const(12'h800, (i >= 18) ? 32'h1 : 32'h0, "sw_debounce");

    // timer
    wr(12'h034, 4'h1, 32'h1);
    idle(40);
    rd_const(12'h030, 32'd10, "timer_40clk");
    wr(12'h034, 4'h1, 32'h3);
    rd_const(12'h030, 32'd0, "timer_clear");
    rd_const(12'h034, 32'd1, "ctrl_readback");
    idle(8);
    rd_const(12'h030, 32'd2, "timer_resume");
    wr(12'h034, 4'h1, 32'h0);
    rd(12'h030, "timer_stop");
    idle(10);
    rd(12'h030, "timer_hold");

    // randomized traffic against the model
    for (int it = 0; it < 400; it++) begin
      int op;
      logic [11:0] a;
      op = $urandom_range(0, 9);
      a = addr_tab[$urandom_range(0, 10)] | 12'($urandom_range(0, 3));
      if (op <= 3) begin
        i_sel = ($urandom_range(0, 3) != 0); i_wren = 1'b1; i_addr = a;
        i_be = 4'($urandom); i_wdata = $urandom;
        step();
        i_sel = 1'b0; i_wren = 1'b0;
      end else if (op <= 6) begin
        rd(a, "rand_read");
      end else if (op == 7) begin
        i_io_sw[$urandom_range(0, SWW - 1)] ^= 1'b1;
        step();
      end else if (op == 8) begin
        chk_outs();
        step();
      end else begin
        idle($urandom_range(1, 20));
        rd(12'h800, "rand_sw");
      end
    end
    chk_outs();
    step();

    // asynchronous reset in the middle of activity
    wr(12'h034, 4'h1, 32'h1);
    wr(12'h000, 4'hF, 32'h0000_1234);
    wr(12'h010, 4'hF, 32'h0000_00C3);
    idle(6);
    #2 i_rst = 1'b0; i_addr = 12'h030;
    #1;
    push(1, 64'h0, "async_ledr"); push(2, 64'h0, "async_ledg");
    push(3, hz, "async_hex"); push(0, 64'h0, "async_rdata");
    ->chk_now;
    #1;
    step();
    i_sel = 1'b1; i_wren = 1'b1; i_addr = 12'h000; i_be = 4'hF; i_wdata = 32'hFFFF;
    idle(2);
    i_rst = 1'b1;
    wr(12'h010, 4'hF, 32'h0000_00A5);
    rd_const(12'h010, 32'h0000_00A5, "release_first_write");
    rd_const(12'h000, 32'h0, "no_write_in_reset");
    rd_const(12'h030, 32'h0, "reset_timer_count");
    chk_outs();
    idle(2);

    if (exp_q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL scoreboard_drain: actual=%0d pending required=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/io_periph_mmio.md
Name: io_periph_mmio

Overview:
- Parametrised memory-mapped I/O subsystem for the single-cycle core; next generation of the fixed LED/HEX/switch handling currently split between the LSU and the seven-segment decoder.
- Sits on the LSU I/O decode path. The LSU forwards any access whose address lies in the I/O window.
- Adds the following over the current design:
  - byte-enabled writes;
  - a configurable digit count;
  - switch synchronisation and debounce;
  - a prescaled free-running timer.
- Reads are same-cycle (combinational from registered state) so the single-cycle datapath is unaffected.

Parameters:
- NUM_HEX, 8, number of seven-segment digits driven (1..8).
- LEDR_W, 17, red LED width (1..32).
- LEDG_W, 8, green LED width (1..32).
- SW_W, 18, switch input width (1..32).
- DEBOUNCE_CYC, 16, consecutive stable cycles required before a switch bit updates. 0 = synchroniser only.
- PRESC, 50, timer increments once every PRESC clocks (>=1).

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst  in  1  asynchronous active-low reset (0 = reset).
- i_sel  in  1  access targets the I/O window this cycle.
- i_wren  in  1  write strobe; valid only with i_sel.
- i_addr  in  12  byte offset within the I/O window.
- i_be  in  4  byte enables for writes.
- i_wdata  in  32  write data.
- o_rdata  out  32  read data, combinational.
- i_io_sw  in  SW_W  raw asynchronous switches.
- o_io_ledr  out  LEDR_W  red LEDs.
- o_io_ledg  out  LEDG_W  green LEDs.
- o_io_hex  out  7*NUM_HEX  segments, active-low, digit k at [7k+6:7k], bit order g..a.

Behaviour:
- Address map (word-aligned; i_addr[1:0] ignored):
  - 0x000 LEDR, RW;
  - 0x010 LEDG, RW;
  - 0x020 HEX0-3, RW, byte k = digit k;
  - 0x024 HEX4-7, RW;
  - 0x030 TIMER count, RO;
  - 0x034 TIMER ctrl, RW: bit0 = enable, bit1 = clear (write-1, self-clearing, reads 0);
  - 0x800 SW, RO (debounced).
  - Unmapped addresses: reads return 0, writes are ignored.
- Writes commit on the rising edge when i_sel & i_wren, only to bytes with i_be set.
- Bits beyond LEDR_W/LEDG_W are not stored and read as 0. Digit bytes >= NUM_HEX are not stored and read as 0.
- Reads: o_rdata reflects register state before the current edge. A same-cycle write is visible on the next cycle.
- Digit byte format: [3:0] = hex value 0-F, [7] = blank, [6:4] reserved (stored, read back).
  - Encoding, active-low: 0 = 7'b1000000 … F = 7'b0001110.
  - Blank = 7'b1111111.
  - Segment outputs are combinational from the digit registers.
- Switches: 2-flop synchroniser per bit, then one counter per bit.
  - The counter resets whenever the synchronised bit differs from the sync value of the previous cycle.
  - When the counter reaches DEBOUNCE_CYC, the debounced bit takes the synced value.
  - Total latency from a stable input change = 2 + DEBOUNCE_CYC cycles.
  - SW read is zero-extended to 32 bits.
- Timer: prescale counter runs 0..PRESC-1 while enable = 1.
  - On wrap, the 32-bit count increments and wraps 0xFFFFFFFF -> 0.
  - Enable = 0 freezes both the prescaler and the count.
  - Clear zeroes both the count and the prescaler on the write edge. Clear wins over an increment in the same cycle.
  - Writing ctrl with bit0 = 1 and bit1 = 1 clears the count and leaves the timer enabled.
- Reset (i_rst = 0, asynchronous, any time including mid-access):
  - LEDR, LEDG, all digit bytes, timer count, prescaler, ctrl, debounced SW, sync flops and counters all go to 0.
  - Digits therefore show "0": o_io_hex digit = 7'b1000000.
  - o_rdata follows the reset state.
- Release is synchronous to the first rising edge with i_rst = 1. No write is accepted during reset.
- i_wren without i_sel has no effect.

Test Plan:
- Reset then idle: o_io_ledr = 0, o_io_ledg = 0, each digit = 7'b1000000, read 0x030 = 0.
- Byte-enabled HEX write: write 0x020 data 0x8A_03_0F_05, be = 4'b0101.
  - Required: digit0 = 5 (7'b0010010), digit2 = 3 (7'b0110000), digit1 and digit3 unchanged at "0".
  - Required: read 0x020 = 0x0003_0005.
- Blank and width clipping: write 0x020 = 0x80, digit0 = 7'b1111111.
  - With LEDR_W = 17, write 0x000 = 0xFFFFFFFF; read 0x000 = 0x0001FFFF.
- Debounce with DEBOUNCE_CYC = 16: toggle sw[0] with a 5-cycle glitch; SW read stays 0.
  - Then hold 1; SW read = 1 exactly 18 cycles after the change.
- Timer with PRESC = 4:
  - Write ctrl = 1 and wait 40 clocks; read count = 10.
  - Write ctrl = 3; next read = 0, and the count continues incrementing.
  - Write ctrl = 0; the count holds.
- Async reset mid-operation: assert i_rst = 0 between clock edges with the timer running and LEDs set.
  - Outputs go to 0 immediately, without waiting for a clock.
  - After release, the first write is accepted on the first clock edge.
